bus_arb_mh: RTL and testbench

- Parametrised multi-host successor to the single-host SoC bus.
- Arbitrates NrHosts requesters (core instruction/data ports, future DMA/debug) onto one shared device bus.
- Supports round-robin or fixed-priority arbitration, base/mask address decode to NrDevices targets, and a registered one-cycle response path.
- Unmapped accesses receive an error response instead of silently aliasing.

---
 rtl/bus_arb_mh.sv | 168 ++++++++++++++++
 tb/tb_bus_arb_mh.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb_mh.sv
// Multi-host bus arbiter: round-robin or fixed-priority grant, base/mask device decode,
// and a registered one-cycle response path with error signalling for unmapped addresses.
module bus_arb_mh #(
    parameter int NrHosts   = 2,
    parameter int NrDevices = 3,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int ArbMode   = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrHosts-1:0]             host_req_i,
    input  logic [NrHosts-1:0]             host_we_i,
    input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
    input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
    output logic [NrHosts-1:0]             host_gnt_o,
    output logic [NrHosts-1:0]             host_rvalid_o,
    output logic [NrHosts-1:0]             host_err_o,
    output logic [NrHosts*DataWidth-1:0]   host_rdata_o,
    output logic [NrDevices-1:0]           device_req_o,
    output logic [NrDevices-1:0]           device_we_o,
    output logic [NrDevices*AddrWidth-1:0] device_addr_o,
    output logic [NrDevices*DataWidth-1:0] device_wdata_o,
    input  logic [NrDevices*DataWidth-1:0] device_rdata_i,
    input  logic [NrDevices*AddrWidth-1:0] cfg_device_addr_base,
    input  logic [NrDevices*AddrWidth-1:0] cfg_device_addr_mask
);

    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic [HostIdxW-1:0]  r_ptr;
    logic [HostIdxW-1:0]  r_respHost;
    logic [DevIdxW-1:0]   r_respDev;
    logic                 r_respValid;
    logic                 r_respErr;
    logic                 r_respWe;

    logic [HostIdxW-1:0]  w_scanBase;
    logic [HostIdxW:0]    w_cand;
    logic [HostIdxW-1:0]  w_winner;
    logic [HostIdxW-1:0]  w_ptrNext;
    logic                 w_found;
    logic [AddrWidth-1:0] w_addr;
    logic [DataWidth-1:0] w_wdata;
    logic                 w_we;
    logic                 w_hit;
    logic [DevIdxW-1:0]   w_dev;
    logic [DataWidth-1:0] w_rdata;

    // Fixed-priority mode is simply a scan that always starts at host 0.
    assign w_scanBase = (ArbMode == 1) ? '0 : r_ptr;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 0; i < NrHosts; i++) begin
            w_cand = {1'b0, w_scanBase} + (HostIdxW+1)'(i);
            if (w_cand >= (HostIdxW+1)'(NrHosts)) begin
                w_cand = w_cand - (HostIdxW+1)'(NrHosts);
            end
            if (!w_found && host_req_i[w_cand[HostIdxW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[HostIdxW-1:0];
            end
        end
    end

    assign w_ptrNext = (({1'b0, w_winner} + 1'b1) >= (HostIdxW+1)'(NrHosts)) ? '0 : w_winner + 1'b1;

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        for (int h = 0; h < NrHosts; h++) begin
            if (w_winner == HostIdxW'(h)) begin
                w_addr  = host_addr_i[h*AddrWidth +: AddrWidth];
                w_wdata = host_wdata_i[h*DataWidth +: DataWidth];
                w_we    = host_we_i[h];
            end
        end
    end

    // Scanning downwards lets the lowest-indexed matching device overwrite higher ones.
    always_comb begin
        w_hit = 1'b0;
        w_dev = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((w_addr & cfg_device_addr_mask[d*AddrWidth +: AddrWidth]) ==
                cfg_device_addr_base[d*AddrWidth +: AddrWidth]) begin
                w_hit = 1'b1;
                w_dev = DevIdxW'(d);
            end
        end
    end

    always_comb begin
        host_gnt_o   = '0;
        device_req_o = '0;
        device_we_o  = '0;
        if (w_found && !rst_i) begin
            for (int h = 0; h < NrHosts; h++) begin
                if (w_winner == HostIdxW'(h)) begin
                    host_gnt_o[h] = 1'b1;
                end
            end
            if (w_hit) begin
                for (int d = 0; d < NrDevices; d++) begin
                    if (w_dev == DevIdxW'(d)) begin
                        device_req_o[d] = 1'b1;
                        device_we_o[d]  = w_we;
                    end
                end
            end
        end
    end

    assign device_addr_o  = {NrDevices{w_addr}};
    assign device_wdata_o = {NrDevices{w_wdata}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr       <= '0;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_respHost  <= '0;
            r_respDev   <= '0;
            r_respWe    <= 1'b0;
        end else begin
            r_respValid <= w_found;
            if (w_found) begin
                r_respHost <= w_winner;
                r_respDev  <= w_hit ? w_dev : '0;
                r_respErr  <= !w_hit;
                r_respWe   <= w_we;
                if (ArbMode == 0) begin
                    r_ptr <= w_ptrNext;
                end
            end
        end
    end

    // Writes and errors return zero data so stale device data never leaks to a host.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        w_rdata       = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (r_respDev == DevIdxW'(d)) begin
                w_rdata = device_rdata_i[d*DataWidth +: DataWidth];
            end
        end
        if (r_respValid && !rst_i) begin
            for (int h = 0; h < NrHosts; h++) begin
                if (r_respHost == HostIdxW'(h)) begin
                    host_rvalid_o[h] = 1'b1;
                    host_err_o[h]    = r_respErr;
                    if (!r_respErr && !r_respWe) begin
                        host_rdata_o[h*DataWidth +: DataWidth] = w_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arb_mh.sv
// Bench for bus_arb_mh: a round-robin and a fixed-priority instance share one stimulus
// stream and are compared every cycle against a transaction-level model of the arbiter.
module tb_bus_arb_mh;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  hostReq, hostWe;
    logic [63:0] hostAddr, hostWdata;
    logic [95:0] devRdata, cfgBase, cfgMask;

    logic [1:0]  rrGnt, rrRvalid, rrErr, fpGnt, fpRvalid, fpErr;
    logic [63:0] rrRdata, fpRdata;
    logic [2:0]  rrDevReq, rrDevWe, fpDevReq, fpDevWe;
    logic [95:0] rrDevAddr, rrDevWdata, fpDevAddr, fpDevWdata;

    int nAsserts = 0;
    int nFail    = 0;

    int unsigned baseTab [3] = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000};
    int unsigned maskTab [3] = '{32'hFF00_0000, 32'hFFF0_0000, 32'hFFFF_0000};

    // Model state per mode (0 = round-robin, 1 = fixed priority)
    int ptrM     [2];
    bit expValid [2];
    int expHost  [2];
    bit expErr   [2];
    int expDev   [2];
    bit expWe    [2];

    always #5 clk_i = ~clk_i;

    assign cfgBase = {baseTab[2], baseTab[1], baseTab[0]};
    assign cfgMask = {maskTab[2], maskTab[1], maskTab[0]};

    bus_arb_mh #(.NrHosts(2), .NrDevices(3), .DataWidth(32), .AddrWidth(32), .ArbMode(0)) dutRr (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_req_i(hostReq), .host_we_i(hostWe), .host_addr_i(hostAddr), .host_wdata_i(hostWdata),
        .host_gnt_o(rrGnt), .host_rvalid_o(rrRvalid), .host_err_o(rrErr), .host_rdata_o(rrRdata),
        .device_req_o(rrDevReq), .device_we_o(rrDevWe), .device_addr_o(rrDevAddr),
        .device_wdata_o(rrDevWdata), .device_rdata_i(devRdata),
        .cfg_device_addr_base(cfgBase), .cfg_device_addr_mask(cfgMask)
    );

    bus_arb_mh #(.NrHosts(2), .NrDevices(3), .DataWidth(32), .AddrWidth(32), .ArbMode(1)) dutFp (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_req_i(hostReq), .host_we_i(hostWe), .host_addr_i(hostAddr), .host_wdata_i(hostWdata),
        .host_gnt_o(fpGnt), .host_rvalid_o(fpRvalid), .host_err_o(fpErr), .host_rdata_o(fpRdata),
        .device_req_o(fpDevReq), .device_we_o(fpDevWe), .device_addr_o(fpDevAddr),
        .device_wdata_o(fpDevWdata), .device_rdata_i(devRdata),
        .cfg_device_addr_base(cfgBase), .cfg_device_addr_mask(cfgMask)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pickWinner(input logic [1:0] req, input int start);
        for (int k = 0; k < 2; k++) begin
            if (req[(start + k) % 2]) return (start + k) % 2;
        end
        return -1;
    endfunction

    function automatic int decodeDev(input logic [31:0] a);
        for (int d = 0; d < 3; d++) begin
            if ((a & maskTab[d]) == baseTab[d]) return d;
        end
        return -1;
    endfunction

    task automatic checkMode(input int m, input logic [1:0] gnt, input logic [2:0] dreq,
                             input logic [2:0] dwe, input logic [1:0] rv, input logic [1:0] er,
                             input logic [63:0] rd, input logic [95:0] daddr, input logic [95:0] dwd);
        string pfx = (m == 0) ? "rr" : "fp";
        int w = -1;
        int d = -1;
        logic [1:0]  eGnt = '0, eRv = '0, eEr = '0;
        logic [2:0]  eReq = '0, eWe = '0;
        logic [63:0] eRd = '0;
        if (!rst_i) begin
            w = pickWinner(hostReq, (m == 0) ? ptrM[0] : 0);
            if (w >= 0) begin
                eGnt[w] = 1'b1;
                d = decodeDev(hostAddr[w*32 +: 32]);
                if (d >= 0) begin
                    eReq[d] = 1'b1;
                    eWe[d]  = hostWe[w];
                end
            end
            if (expValid[m]) begin
                eRv[expHost[m]] = 1'b1;
                eEr[expHost[m]] = expErr[m];
                if (!expErr[m] && !expWe[m]) eRd[expHost[m]*32 +: 32] = devRdata[expDev[m]*32 +: 32];
            end
        end
        chk({pfx, " gnt"}, 96'(gnt), 96'(eGnt));
        chk({pfx, " devReq"}, 96'(dreq), 96'(eReq));
        chk({pfx, " devWe"}, 96'(dwe), 96'(eWe));
        chk({pfx, " rvalid"}, 96'(rv), 96'(eRv));
        chk({pfx, " err"}, 96'(er), 96'(eEr));
        chk({pfx, " rdata"}, 96'(rd), 96'(eRd));
        if (w >= 0) begin
            chk({pfx, " devAddr"}, daddr, {3{hostAddr[w*32 +: 32]}});
            chk({pfx, " devWdata"}, dwd, {3{hostWdata[w*32 +: 32]}});
        end
        if (rst_i) begin
            ptrM[m]     = 0;
            expValid[m] = 1'b0;
        end else begin
            expValid[m] = (w >= 0);
            if (w >= 0) begin
                expHost[m] = w;
                expDev[m]  = d;
                expErr[m]  = (d < 0);
                expWe[m]   = hostWe[w];
                if (m == 0) ptrM[m] = (w + 1) % 2;
            end
        end
    endtask

    task automatic checkOutput();
        checkMode(0, rrGnt, rrDevReq, rrDevWe, rrRvalid, rrErr, rrRdata, rrDevAddr, rrDevWdata);
        checkMode(1, fpGnt, fpDevReq, fpDevWe, fpRvalid, fpErr, fpRdata, fpDevAddr, fpDevWdata);
    endtask

    task automatic applyStimulus(input logic rst, input logic [1:0] req, input logic [1:0] we,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] wd0, input logic [31:0] wd1,
                                 input logic [95:0] rd);
        @(negedge clk_i);
        rst_i     = rst;
        hostReq   = req;
        hostWe    = we;
        hostAddr  = {a1, a0};
        hostWdata = {wd1, wd0};
        devRdata  = rd;
        #1;
        checkOutput();
    endtask

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 3))
            0:       return $urandom & 32'h00FF_FFFF;
            1:       return 32'h0100_0000 | ($urandom & 32'h001F_FFFF);
            2:       return 32'h0200_0000 | ($urandom & 32'h0001_FFFF);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        $display("[TB] starting bus_arb_mh test");
        rst_i = 1'b1; hostReq = '0; hostWe = '0; hostAddr = '0; hostWdata = '0; devRdata = '0;
        for (int m = 0; m < 2; m++) begin
            ptrM[m] = 0; expValid[m] = 0; expHost[m] = 0; expErr[m] = 0; expDev[m] = 0; expWe[m] = 0;
        end

        applyStimulus(1, 2'b11, 2'b00, 32'h10, 32'h10, 0, 0, '0);
        applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0, '0);

        // Single read from device 0
        applyStimulus(0, 2'b01, 2'b00, 32'h0000_0010, 0, 0, 0, '0);
        chk("single gnt", 96'(rrGnt), 96'(2'b01));
        chk("single devReq", 96'(rrDevReq), 96'(3'b001));
        applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, {64'h0, 32'hDEAD_BEEF});
        chk("single rvalid", 96'(rrRvalid), 96'(2'b01));
        chk("single rdata", 96'(rrRdata[31:0]), 96'(32'hDEAD_BEEF));

        // Host1 alone moves the round-robin pointer back to host 0
        applyStimulus(0, 2'b10, 2'b00, 0, 32'h0100_0000, 0, 0, '0);

        // Round-robin alternation while both hosts request
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 2'b11, 2'b00, 32'h20, 32'h0100_0000, 0, 0, {$urandom, $urandom, $urandom});
            chk("rr alternate", 96'(rrGnt), (k % 2 == 0) ? 96'(2'b01) : 96'(2'b10));
            chk("fp priority", 96'(fpGnt), 96'(2'b01));
        end
        applyStimulus(0, 2'b11, 2'b00, 32'h20, 32'h0100_0000, 0, 0, '0);
        applyStimulus(0, 2'b10, 2'b00, 32'h20, 32'h0100_0000, 0, 0, '0);
        chk("fp host1 after drop", 96'(fpGnt), 96'(2'b10));

        // Unmapped write from host 1
        applyStimulus(0, 2'b10, 2'b10, 0, 32'h0300_0000, 0, 32'h55, '0);
        chk("unmapped gnt", 96'(rrGnt), 96'(2'b10));
        chk("unmapped devReq", 96'(rrDevReq), 96'(3'b000));
        applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, {3{32'hFFFF_FFFF}});
        chk("unmapped err", 96'({rrRvalid, rrErr}), 96'(4'b1010));
        chk("unmapped rdata", 96'(rrRdata[63:32]), 96'(32'h0));

        // Console write to device 1
        applyStimulus(0, 2'b01, 2'b01, 32'h0100_0004, 0, 32'h41, 0, '0);
        chk("console devReq", 96'(rrDevReq), 96'(3'b010));
        chk("console devWe", 96'(rrDevWe), 96'(3'b010));
        chk("console wdata", 96'(rrDevWdata[63:32]), 96'(32'h41));
        applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, {3{32'h1234_5678}});
        chk("console resp", 96'({rrRvalid, rrErr}), 96'(4'b0100));

        // Reset while a response is outstanding
        applyStimulus(0, 2'b01, 2'b00, 32'h10, 0, 0, 0, '0);
        applyStimulus(1, 2'b00, 2'b00, 0, 0, 0, 0, '0);
        chk("reset drops rvalid", 96'(rrRvalid), 96'(2'b00));
        applyStimulus(0, 2'b11, 2'b00, 32'h10, 32'h10, 0, 0, '0);
        chk("reset ptr host0 wins", 96'(rrGnt), 96'(2'b01));
        applyStimulus(0, 2'b00, 2'b00, 0, 0, 0, 0, '0);
        chk("no stale rvalid h1", 96'(rrRvalid[1]), 96'(1'b0));

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom), 2'($urandom),
                          randAddr(), randAddr(), $urandom, $urandom,
                          {$urandom, $urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
